dmem_arbiter: RTL and testbench

- Two-requester arbiter and sequencer for the single-port word data memory (Data_Memory: Addr, Write, Read, WE, clk).
- Requester 0 is the core load/store unit; requester 1 is the debug/test loader.
- Serialises accesses with a two-state FSM and grants round-robin, so neither requester starves.
- Returns read data with a registered valid pulse and flags misaligned addresses.

---
 rtl/dmem_arbiter.sv | 164 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Two-requester arbiter and sequencer in front of a single-port word data
//   memory with combinational read. Requester 0 is the core load/store unit,
//   requester 1 is the debug/test loader. Accesses are serialised through a
//   two-state FSM, so there is at most one access every two cycles. When both
//   requesters ask together they are served round-robin. Read data comes back
//   in a register, with a one-cycle valid pulse. Misaligned addresses are
//   flagged and never write the memory.
//
//   state  | meaning
//   -------+-----------------------------------------------------------------
//   IDLE   | no access in flight; requests are sampled at the rising edge
//   ACCESS | owner drives the memory; owner gnt is high; always back to IDLE
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   mX_req/we/addr/wdata           requester X access request (held to gnt)
//   mX_gnt                         one-cycle grant (the ACCESS cycle)
//   mX_rvalid/rdata/err            registered response; err qualified by rvalid
//   mem_addr/mem_wdata/mem_we      to Data_Memory Addr/Write/WE
//   mem_rdata                      from Data_Memory Read
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_err,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_err,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   r_owner;
    logic   r_prio;
    logic   w_owner_nxt;
    logic   w_prio_nxt;

    logic              w_access;
    logic              w_own_we;
    logic [ADDR_W-1:0] w_own_addr;
    logic [DATA_W-1:0] w_own_wdata;
    logic              w_aligned;

    logic              r_m0_rvalid;
    logic [DATA_W-1:0] r_m0_rdata;
    logic              r_m0_err;
    logic              r_m1_rvalid;
    logic [DATA_W-1:0] r_m1_rdata;
    logic              r_m1_err;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_owner <= 1'b0;
            r_prio  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_prio  <= w_prio_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_prio_nxt  = r_prio;
        case (r_state)
            ST_IDLE: begin
                if (m0_req || m1_req) begin
                    w_state_nxt = ST_ACCESS;
                    // A lone requester wins outright; a tie goes to prio.
                    w_owner_nxt = (m0_req && m1_req) ? r_prio : m1_req;
                    // The loser of this round gets the next tie.
                    w_prio_nxt  = ~w_owner_nxt;
                end
            end
            ST_ACCESS: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        w_access    = (r_state == ST_ACCESS);
        w_own_we    = r_owner ? m1_we    : m0_we;
        w_own_addr  = r_owner ? m1_addr  : m0_addr;
        w_own_wdata = r_owner ? m1_wdata : m0_wdata;
        w_aligned   = (w_own_addr[1:0] == 2'b00);

        mem_addr    = w_own_addr;
        mem_wdata   = w_own_wdata;
        // Decoded from the async-reset state, so WE falls as soon as rst_n does.
        mem_we      = w_access & w_own_we & w_aligned;
        m0_gnt      = w_access & ~r_owner;
        m1_gnt      = w_access &  r_owner;

        m0_rvalid   = r_m0_rvalid;
        m0_rdata    = r_m0_rdata;
        m0_err      = r_m0_err;
        m1_rvalid   = r_m1_rvalid;
        m1_rdata    = r_m1_rdata;
        m1_err      = r_m1_err;
    end

    // Response capture at the end of ACCESS. rdata is the pre-write word for
    // stores because the memory read is combinational on the same address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m0_rvalid <= 1'b0;
            r_m0_rdata  <= '0;
            r_m0_err    <= 1'b0;
            r_m1_rvalid <= 1'b0;
            r_m1_rdata  <= '0;
            r_m1_err    <= 1'b0;
        end else begin
            r_m0_rvalid <= m0_gnt;
            r_m1_rvalid <= m1_gnt;
            if (m0_gnt) begin
                r_m0_rdata <= mem_rdata;
                r_m0_err   <= ~w_aligned;
            end
            if (m1_gnt) begin
                r_m1_rdata <= mem_rdata;
                r_m1_err   <= ~w_aligned;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        m0_req, m0_we, m0_gnt, m0_rvalid, m0_err;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic        m1_req, m1_we, m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .m0_req   (m0_req),
        .m0_we    (m0_we),
        .m0_addr  (m0_addr),
        .m0_wdata (m0_wdata),
        .m0_gnt   (m0_gnt),
        .m0_rvalid(m0_rvalid),
        .m0_rdata (m0_rdata),
        .m0_err   (m0_err),
        .m1_req   (m1_req),
        .m1_we    (m1_we),
        .m1_addr  (m1_addr),
        .m1_wdata (m1_wdata),
        .m1_gnt   (m1_gnt),
        .m1_rvalid(m1_rvalid),
        .m1_rdata (m1_rdata),
        .m1_err   (m1_err),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_we   (mem_we),
        .mem_rdata(mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Data_Memory stand-in: 256 words, combinational read, write on rising edge.
    logic [31:0] tb_mem [0:255];
    initial begin
        for (int i = 0; i < 256; i++) tb_mem[i] = 32'h0;
    end
    assign mem_rdata = tb_mem[mem_addr[9:2]];
    always @(posedge clk) begin
        if (mem_we) tb_mem[mem_addr[9:2]] <= mem_wdata;
    end

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    // Reference model: pending transactions per requester, expected memory
    // contents, which requester was served last, and whether one access is
    // in flight (its response is due at the next edge).
    txn_t        q0[$];
    txn_t        q1[$];
    logic [31:0] ref_mem [int];
    int          m_last;
    bit          m_busy;
    int          m_own;
    logic [31:0] exp_rd0, exp_rd1;
    int          glog[$];

    int n_total;
    int n_bad;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        int k;
        k = int'(a[9:2]);
        return ref_mem.exists(k) ? ref_mem[k] : 32'h0;
    endfunction

    task automatic drive();
        if (q0.size() > 0) begin
            m0_req = 1'b1; m0_we = q0[0].we; m0_addr = q0[0].addr; m0_wdata = q0[0].wdata;
        end else begin
            m0_req = 1'b0;
        end
        if (q1.size() > 0) begin
            m1_req = 1'b1; m1_we = q1[0].we; m1_addr = q1[0].addr; m1_wdata = q1[0].wdata;
        end else begin
            m1_req = 1'b0;
        end
    endtask

    task automatic push0(input logic we, input logic [31:0] a, input logic [31:0] d);
        txn_t t;
        t.we = we; t.addr = a; t.wdata = d;
        q0.push_back(t);
        drive();
    endtask

    task automatic push1(input logic we, input logic [31:0] a, input logic [31:0] d);
        txn_t t;
        t.we = we; t.addr = a; t.wdata = d;
        q1.push_back(t);
        drive();
    endtask

    // One clock: advance the model over the edge, compare, re-drive inputs.
    task automatic step();
        logic exp_g0, exp_g1, exp_rv0, exp_rv1, exp_we;
        txn_t t;
        int   w;
        @(posedge clk);
        #1;
        exp_g0 = 0; exp_g1 = 0; exp_rv0 = 0; exp_rv1 = 0; exp_we = 0;
        if (m0_gnt) glog.push_back(0);
        if (m1_gnt) glog.push_back(1);
        if (m_busy) begin
            w = m_own;
            t = (w == 0) ? q0[0] : q1[0];
            if (w == 0) begin
                exp_rv0 = 1; exp_rd0 = ref_rd(t.addr);
                check_val("m0_err", m0_err, (t.addr[1:0] != 2'b00));
                void'(q0.pop_front());
            end else begin
                exp_rv1 = 1; exp_rd1 = ref_rd(t.addr);
                check_val("m1_err", m1_err, (t.addr[1:0] != 2'b00));
                void'(q1.pop_front());
            end
            if (t.we && t.addr[1:0] == 2'b00) ref_mem[int'(t.addr[9:2])] = t.wdata;
            m_busy = 0;
        end else if (q0.size() > 0 || q1.size() > 0) begin
            if (q0.size() > 0 && q1.size() > 0) w = 1 - m_last;
            else w = (q0.size() > 0) ? 0 : 1;
            t = (w == 0) ? q0[0] : q1[0];
            m_busy = 1; m_own = w; m_last = w;
            if (w == 0) exp_g0 = 1; else exp_g1 = 1;
            exp_we = t.we && (t.addr[1:0] == 2'b00);
            check_val("mem_addr", mem_addr, t.addr);
            if (exp_we) check_val("mem_wdata", mem_wdata, t.wdata);
        end
        check_val("m0_gnt", m0_gnt, exp_g0);
        check_val("m1_gnt", m1_gnt, exp_g1);
        check_val("mem_we", mem_we, exp_we);
        check_val("m0_rvalid", m0_rvalid, exp_rv0);
        check_val("m1_rvalid", m1_rvalid, exp_rv1);
        check_val("m0_rdata", m0_rdata, exp_rd0);
        check_val("m1_rdata", m1_rdata, exp_rd1);
        drive();
    endtask

    task automatic drain(input int max_cyc);
        int n;
        n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || m_busy) && n < max_cyc) begin
            step();
            n++;
        end
        if (q0.size() > 0 || q1.size() > 0 || m_busy) begin
            check_val("drain_timeout", 32'd1, 32'd0);
            q0.delete(); q1.delete(); m_busy = 0;
            drive();
        end
    endtask

    // Asserts reset from wherever the bench currently is, checks the
    // immediate effect, then releases between clock edges.
    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        q0.delete(); q1.delete();
        m_busy = 0; m_last = 1; exp_rd0 = 0; exp_rd1 = 0;
        drive();
        check_val("rst_mem_we", mem_we, 0);
        check_val("rst_m0_gnt", m0_gnt, 0);
        check_val("rst_m1_gnt", m1_gnt, 0);
        check_val("rst_m0_rvalid", m0_rvalid, 0);
        check_val("rst_m1_rvalid", m1_rvalid, 0);
        check_val("rst_m0_err", m0_err, 0);
        check_val("rst_m1_err", m1_err, 0);
        check_val("rst_m0_rdata", m0_rdata, 0);
        check_val("rst_m1_rdata", m1_rdata, 0);
        @(posedge clk);
        @(posedge clk);
        #3;
        check_val("rst_m0_rvalid_hold", m0_rvalid, 0);
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int c0;
        n_total = 0; n_bad = 0;
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
        rst_n = 1'b1;
        #2;
        apply_reset();

        // Single write then read, requester 0
        push0(1'b1, 32'd96, 32'd7);
        drain(20);
        check_val("wr96_err", m0_err, 0);
        push0(1'b0, 32'd96, 32'd0);
        drain(20);
        check_val("rd96", m0_rdata, 32'd7);

        // Simultaneous requests straight after reset: m0 first
        apply_reset();
        glog.delete();
        push0(1'b1, 32'd100, 32'd25);
        push1(1'b0, 32'd96, 32'd0);
        drain(20);
        check_val("simul_n", glog.size(), 2);
        if (glog.size() == 2) begin
            check_val("simul_first", glog[0], 0);
            check_val("simul_second", glog[1], 1);
        end
        check_val("simul_m1_rd", m1_rdata, 32'd7);

        // Starvation: both held for 8 accesses, strictly alternating from m0
        glog.delete();
        for (int i = 0; i < 4; i++) begin
            push0(1'b1, 32'd512 + 32'(i * 4), 32'(i + 32'h100));
            push1(1'b0, 32'd512 + 32'(i * 4), 32'd0);
        end
        drain(40);
        check_val("starve_n", glog.size(), 8);
        c0 = 0;
        for (int i = 0; i < glog.size(); i++) begin
            check_val("starve_order", glog[i], i % 2);
            if (glog[i] == 0) c0++;
        end
        check_val("starve_m0_cnt", c0, 4);

        // Misaligned store from m1: no write, err flagged
        push1(1'b1, 32'd98, 32'h0000DEAD);
        drain(20);
        push1(1'b0, 32'd96, 32'd0);
        drain(20);
        check_val("misal_rd96", m1_rdata, 32'd7);

        // Reset in the middle of an ACCESS cycle
        push0(1'b1, 32'd100, 32'h55);
        n = 0;
        while (!m_busy && n < 10) begin
            step();
            n++;
        end
        check_val("midrst_reached_access", m_busy, 1);
        check_val("midrst_we_before", mem_we, 1);
        #2;
        apply_reset();
        for (int i = 0; i < 3; i++) step();
        push0(1'b0, 32'd100, 32'd0);
        drain(20);
        check_val("midrst_rd100", m0_rdata, 32'd25);

        // Store returns the pre-write word
        push0(1'b1, 32'd96, 32'd9);
        drain(20);
        check_val("store_prewrite", m0_rdata, 32'd7);
        push0(1'b0, 32'd96, 32'd0);
        drain(20);
        check_val("store_readback", m0_rdata, 32'd9);

        // Randomised traffic
        for (int cyc = 0; cyc < 600; cyc++) begin
            if ($urandom_range(0, 2) == 0 && q0.size() < 3)
                push0(1'($urandom_range(0, 1)),
                      {22'b0, 8'($urandom_range(0, 255)),
                       ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00},
                      $urandom);
            if ($urandom_range(0, 2) == 0 && q1.size() < 3)
                push1(1'($urandom_range(0, 1)),
                      {22'b0, 8'($urandom_range(0, 255)),
                       ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00},
                      $urandom);
            step();
        end
        drain(100);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
